// File: rtl/fetch_decode_queue_if.sv
// Fetch/decode handshake bundle for the fetch-to-decode instruction queue.
// The master side is the pipeline around the queue; the slave side is the queue itself.
interface fetch_decode_queue_if #(
   parameter int unsigned DPW   = 32,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CW    = $clog2(DEPTH + 1)
);
   logic [DPW-1:0] PCF;
   logic [DPW-1:0] instrF;
   logic           validF;
   logic           readyF;
   logic           stallD;
   logic           flushD;
   logic [DPW-1:0] instrD;
   logic [DPW-1:0] PCD;
   logic           validD;
   logic [CW-1:0]  count;

   modport master (
      output PCF, instrF, validF, stallD, flushD,
      input  readyF, instrD, PCD, validD, count
   );

   modport slave (
      input  PCF, instrF, validF, stallD, flushD,
      output readyF, instrD, PCD, validD, count
   );
endinterface

// File: rtl/fetch_decode_queue.sv
// In-order fetch queue in front of the decode register. Fetches go straight to decode when
// the FIFO is empty and decode advances; otherwise they are queued. Flush or reset empties
// everything and leaves a NOP bubble in decode.
module fetch_decode_queue #(
   parameter int unsigned    DPW   = 32,
   parameter int unsigned    DEPTH = 4,
   parameter logic [DPW-1:0] NOP   = 32'h0000_0013,
   parameter int unsigned    CW    = $clog2(DEPTH + 1)
) (
   input logic                 clk,
   input logic                 rst_n,
   fetch_decode_queue_if.slave bus
);
   localparam int unsigned PW = $clog2(DEPTH);

   logic [DPW-1:0] mem_pc    [DEPTH];
   logic [DPW-1:0] mem_instr [DEPTH];

   logic [PW-1:0]  wr_ptr_q;
   logic [PW-1:0]  rd_ptr_q;
   logic [CW-1:0]  count_q;
   logic [CW-1:0]  count_d;
   logic           valid_d_q;
   logic [DPW-1:0] instr_d_q;
   logic [DPW-1:0] pc_d_q;

   logic full;
   logic enq;
   logic advance;
   logic deq;
   logic bypass;
   logic push;

   // Handshake decode; full comes from the registered count only, no same-cycle lookahead.
   always_comb begin
      full    = (count_q == CW'(DEPTH));
      enq     = bus.validF && !full && !bus.flushD;
      advance = !bus.stallD && !bus.flushD;
      deq     = advance && (count_q != '0);
      bypass  = advance && (count_q == '0) && enq;
      push    = enq && !bypass;
      count_d = count_q;
      case ({push, deq})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO storage; contents need no reset since count gates every read.
   always_ff @(posedge clk) begin
      if (rst_n && push) begin
         mem_pc[wr_ptr_q]    <= bus.PCF;
         mem_instr[wr_ptr_q] <= bus.instrF;
      end
   end

   // Pointers, occupancy and the decode register; reset and flush clear identically.
   always_ff @(posedge clk) begin
      if (!rst_n || bus.flushD) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         valid_d_q <= 1'b0;
         instr_d_q <= NOP;
         pc_d_q    <= '0;
      end else begin
         count_q <= count_d;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
         end
         if (deq) begin
            rd_ptr_q  <= rd_ptr_q + PW'(1);
            valid_d_q <= 1'b1;
            instr_d_q <= mem_instr[rd_ptr_q];
            pc_d_q    <= mem_pc[rd_ptr_q];
         end else if (bypass) begin
            valid_d_q <= 1'b1;
            instr_d_q <= bus.instrF;
            pc_d_q    <= bus.PCF;
         end else if (advance) begin
            // Bubble: PC is left as-is so a debugger still sees the last decoded address.
            valid_d_q <= 1'b0;
            instr_d_q <= NOP;
         end
      end
   end

   // Outputs come only from registers.
   assign bus.readyF = !full;
   assign bus.instrD = instr_d_q;
   assign bus.PCD    = pc_d_q;
   assign bus.validD = valid_d_q;
   assign bus.count  = count_q;
endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed bench for fetch_decode_queue: a queue-based reference model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_fetch_decode_queue;
   localparam int unsigned DPW   = 32;
   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;
   bit   mon_en;

   fetch_decode_queue_if #(.DPW(DPW), .DEPTH(DEPTH)) bus ();

   fetch_decode_queue #(.DPW(DPW), .DEPTH(DEPTH), .NOP(NOP)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: a plain queue of accepted fetches plus the decode slot.
   ent_t        mq[$];
   logic        m_valid = 1'b0;
   logic [31:0] m_instr = NOP;
   logic [31:0] m_pc    = '0;

   always @(posedge clk) begin
      ent_t e;
      bit   acc;
      if (!rst_n || bus.flushD) begin
         mq.delete();
         m_valid = 1'b0;
         m_instr = NOP;
         m_pc    = '0;
      end else begin
         acc = bus.validF && (mq.size() != DEPTH);
         if (!bus.stallD) begin
            if (mq.size() > 0) begin
               e       = mq.pop_front();
               m_valid = 1'b1;
               m_pc    = e.pc;
               m_instr = e.instr;
               if (acc) mq.push_back('{pc: bus.PCF, instr: bus.instrF});
            end else if (acc) begin
               m_valid = 1'b1;
               m_pc    = bus.PCF;
               m_instr = bus.instrF;
            end else begin
               m_valid = 1'b0;
               m_instr = NOP;
            end
         end else if (acc) begin
            mq.push_back('{pc: bus.PCF, instr: bus.instrF});
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare against the model, away from the active edge.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("m.readyF", 32'(bus.readyF), 32'(mq.size() != DEPTH));
         chk("m.validD", 32'(bus.validD), 32'(m_valid));
         chk("m.instrD", bus.instrD, m_instr);
         chk("m.PCD", bus.PCD, m_pc);
         chk("m.count", 32'(bus.count), 32'(mq.size()));
      end
   end

   function automatic logic [31:0] ins_of(input logic [31:0] pc);
      return pc ^ 32'h00A0_0093;
   endfunction

   task automatic set_in(input logic v, input logic [31:0] pc, input logic st,
                         input logic fl, input logic rn);
      bus.validF = v;
      bus.PCF    = pc;
      bus.instrF = ins_of(pc);
      bus.stallD = st;
      bus.flushD = fl;
      rst_n      = rn;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input logic v, input logic [31:0] pc, input logic st,
                        input logic fl, input logic rn);
      set_in(v, pc, st, fl, rn);
      tick();
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      mon_en      = 1'b0;
      set_in(1'b0, '0, 1'b0, 1'b0, 1'b0);
      tick();
      mon_en = 1'b1;
      apply(1'b1, 32'h999, 1'b0, 1'b0, 1'b0);
      chk("rst.validD", 32'(bus.validD), 32'd0);
      chk("rst.instrD", bus.instrD, NOP);
      chk("rst.PCD", bus.PCD, 32'h0);
      chk("rst.count", 32'(bus.count), 32'd0);
      chk("rst.readyF", 32'(bus.readyF), 32'd1);

      // 1: bypass into an empty queue
      set_in(1'b1, 32'h100, 1'b0, 1'b0, 1'b1);
      bus.instrF = 32'h0050_0093;
      tick();
      chk("byp.validD", 32'(bus.validD), 32'd1);
      chk("byp.PCD", bus.PCD, 32'h100);
      chk("byp.instrD", bus.instrD, 32'h0050_0093);
      chk("byp.count", 32'(bus.count), 32'd0);
      chk("byp.model_pc", m_pc, 32'h100);

      // 2: fill under stall, refuse when full, then drain in order
      for (int i = 0; i < 4; i++) begin
         apply(1'b1, 32'h100 + 32'(4 * i), 1'b1, 1'b0, 1'b1);
         chk("fill.count", 32'(bus.count), 32'(i + 1));
      end
      chk("fill.readyF", 32'(bus.readyF), 32'd0);
      chk("fill.model_n", 32'(mq.size()), 32'd4);
      apply(1'b1, 32'h110, 1'b1, 1'b0, 1'b1);
      chk("refuse.count", 32'(bus.count), 32'd4);
      for (int i = 0; i < 4; i++) begin
         apply(1'b0, '0, 1'b0, 1'b0, 1'b1);
         chk("drain.PCD", bus.PCD, 32'h100 + 32'(4 * i));
         chk("drain.validD", 32'(bus.validD), 32'd1);
      end
      apply(1'b0, '0, 1'b0, 1'b0, 1'b1);
      chk("bubble.validD", 32'(bus.validD), 32'd0);
      chk("bubble.instrD", bus.instrD, 32'h0000_0013);
      chk("bubble.PCD", bus.PCD, 32'h10C);

      // 3: steady enqueue+dequeue at count 2 across pointer wrap
      apply(1'b1, 32'h200, 1'b1, 1'b0, 1'b1);
      apply(1'b1, 32'h204, 1'b1, 1'b0, 1'b1);
      chk("steady.count0", 32'(bus.count), 32'd2);
      for (int i = 0; i < 12; i++) begin
         apply(1'b1, 32'h208 + 32'(4 * i), 1'b0, 1'b0, 1'b1);
         chk("steady.count", 32'(bus.count), 32'd2);
         chk("steady.PCD", bus.PCD, 32'h200 + 32'(4 * i));
      end

      // 4: flush with a same-cycle fetch
      apply(1'b1, 32'h238, 1'b1, 1'b0, 1'b1);
      chk("pre_flush.count", 32'(bus.count), 32'd3);
      chk("pre_flush.validD", 32'(bus.validD), 32'd1);
      apply(1'b1, 32'h300, 1'b0, 1'b1, 1'b1);
      chk("flush.count", 32'(bus.count), 32'd0);
      chk("flush.validD", 32'(bus.validD), 32'd0);
      chk("flush.instrD", bus.instrD, NOP);
      chk("flush.PCD", bus.PCD, 32'h0);
      apply(1'b0, '0, 1'b0, 1'b0, 1'b1);
      chk("post_flush.validD", 32'(bus.validD), 32'd0);
      chk("post_flush.PCD", bus.PCD, 32'h0);

      // 5: full queue refuses while draining, accepts the held fetch next cycle
      for (int i = 0; i < 4; i++) apply(1'b1, 32'h400 + 32'(4 * i), 1'b1, 1'b0, 1'b1);
      set_in(1'b1, 32'h410, 1'b0, 1'b0, 1'b1);
      chk("full.readyF", 32'(bus.readyF), 32'd0);
      tick();
      chk("full.count", 32'(bus.count), 32'd3);
      chk("full.readyF1", 32'(bus.readyF), 32'd1);
      chk("full.PCD", bus.PCD, 32'h400);
      tick();
      chk("held.count", 32'(bus.count), 32'd3);
      for (int i = 0; i < 4; i++) apply(1'b0, '0, 1'b0, 1'b0, 1'b1);
      chk("held.PCD", bus.PCD, 32'h410);
      chk("held.count0", 32'(bus.count), 32'd0);

      // 6: reset mid-stream, then bypass
      apply(1'b1, 32'h500, 1'b1, 1'b0, 1'b1);
      apply(1'b1, 32'h504, 1'b1, 1'b0, 1'b1);
      chk("pre_rst.count", 32'(bus.count), 32'd2);
      apply(1'b1, 32'h600, 1'b0, 1'b0, 1'b0);
      chk("mid_rst.count", 32'(bus.count), 32'd0);
      chk("mid_rst.validD", 32'(bus.validD), 32'd0);
      chk("mid_rst.instrD", bus.instrD, NOP);
      chk("mid_rst.PCD", bus.PCD, 32'h0);
      apply(1'b1, 32'h700, 1'b0, 1'b0, 1'b1);
      chk("post_rst.validD", 32'(bus.validD), 32'd1);
      chk("post_rst.PCD", bus.PCD, 32'h700);
      chk("post_rst.instrD", bus.instrD, ins_of(32'h700));
      apply(1'b0, '0, 1'b0, 1'b0, 1'b1);
      chk("tail.validD", 32'(bus.validD), 32'd0);
      @(negedge clk);
      mon_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
